alu_seq: RTL and testbench

Parametrised, registered ALU with valid/ready handshakes on its input and output, and an internal status-flag register (C/Z/N/V).
- Add-with-carry and subtract-with-borrow take their carry from the stored C flag, so multi-word arithmetic can be chained without external glue.
- Adds shift operations and an optional iterative multiplier.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 48 ++++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the alu_seq slice.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_ADC  = 4'b0010,
    OP_SBC  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_XNOR = 4'b1001,
    OP_LT   = 4'b1010,
    OP_GT   = 4'b1011,
    OP_EQ   = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_SHL  = 4'b1110,
    OP_SHR  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_MUL_DONE
  } state_e;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier. The first iteration runs on the start
// edge from the raw operands, so the product is final WIDTH-1 edges after start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand, hi, lo;
  logic [WIDTH-1:0] h_src, l_src, m_src;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt;

  always_comb begin
    h_src = start ? '0 : hi;
    l_src = start ? b  : lo;
    m_src = start ? a  : mcand;
    sum   = {1'b0, h_src} + ({1'b0, m_src} & {(WIDTH + 1){l_src[0]}});
  end

  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));
  assign product = {hi, lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (start || busy) begin
      if (start) mcand <= a;
      hi  <= sum[WIDTH:1];
      lo  <= {sum[0], l_src[WIDTH-1:1]};
      cnt <= start ? CW'(WIDTH - 1) : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a persistent C/Z/N/V flag register.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 1101 (else it runs as ADD).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic [3:0]       flags;
  logic [3:0]       sc_flags;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] r;
  logic             c_n, v_n;
  logic             load_single;

  assign op        = alu_op_e'(alu_sel);
  assign carry_out = flags[FLG_C];
  assign zero      = flags[FLG_Z];
  assign negative  = flags[FLG_N];
  assign overflow  = flags[FLG_V];

  // Single-cycle datapath; C defaults to the stored flag so non-arithmetic ops hold it.
  always_comb begin
    ext = '0;
    r   = '0;
    c_n = flags[FLG_C];
    v_n = 1'b0;
    case (op)
`ifdef ALU_MUL_EN
      OP_ADD, OP_ADC: begin
`else
      OP_ADD, OP_ADC, OP_MUL: begin
`endif
        ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & flags[FLG_C]};
        r   = ext[WIDTH-1:0];
        c_n = ext[WIDTH];
        v_n = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & flags[FLG_C]};
        r   = ext[WIDTH-1:0];
        c_n = ext[WIDTH];
        v_n = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_LT:   r = {{(WIDTH - 1){1'b0}}, a < b};
      OP_GT:   r = {{(WIDTH - 1){1'b0}}, a > b};
      OP_EQ:   r = {{(WIDTH - 1){1'b0}}, a == b};
      OP_SHL:  r = a << b[SHW-1:0];
      OP_SHR:  r = a >> b[SHW-1:0];
      default: ;
    endcase
    sc_flags        = '0;
    sc_flags[FLG_C] = c_n;
    sc_flags[FLG_Z] = (r == '0);
    sc_flags[FLG_N] = r[WIDTH-1];
    sc_flags[FLG_V] = v_n;
  end

`ifdef ALU_MUL_EN
  state_e             state, state_n;
  logic               mul_start, mul_busy, mul_done, load_mul;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_flags;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready    = 1'b0;
    mul_start   = 1'b0;
    load_single = 1'b0;
    load_mul    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_n   = ST_MUL_RUN;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      ST_MUL_RUN:  if (mul_done || !mul_busy) state_n = ST_MUL_DONE;
      ST_MUL_DONE: begin
        load_mul = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLG_Z] = (mul_prod == '0);
    mul_flags[FLG_N] = mul_prod[WIDTH-1];
  end
`else
  assign in_ready    = !out_valid || out_ready;
  assign load_single = in_valid && in_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= r;
      result_hi <= '0;
      flags     <= sc_flags;
`ifdef ALU_MUL_EN
    end else if (load_mul) begin
      out_valid <= 1'b1;
      result    <= mul_prod[WIDTH-1:0];
      result_hi <= mul_prod[2*WIDTH-1:WIDTH];
      flags     <= mul_flags;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors push expected results,
// a monitor pops and compares on every output transfer.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [3:0] alu_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result, result_hi;
  logic       carry_out, zero, negative, overflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] cznv;
  } exp_t;

  exp_t sb[$];

`ifdef ALU_MUL_EN
  localparam int unsigned MUL_LAT = 9;
`else
  localparam int unsigned MUL_LAT = 1;
`endif

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry_out (carry_out),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: a transfer happens at the next rising edge whenever valid && ready now.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got res=%h hi=%h, required no output", result, result_hi);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || result_hi !== e.hi ||
            {carry_out, zero, negative, overflow} !== e.cznv) begin
          miscompares++;
          $display("FAIL %s: got res=%h hi=%h cznv=%b, required res=%h hi=%h cznv=%b",
                   e.tag, result, result_hi, {carry_out, zero, negative, overflow},
                   e.res, e.hi, e.cznv);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", tag, got, req);
    end
  endtask

  // Issues one operation; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input string tag, input logic [3:0] op, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] er, input logic [7:0] eh,
                      input logic [3:0] ef);
    int unsigned n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    alu_sel  = op;
    a        = aa;
    b        = bb;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_accept: in_ready got 0, required 1 within 100 cycles", tag);
    end else begin
      sb.push_back('{tag, er, eh, ef});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int unsigned n;
    logic        seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    alu_sel   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_outputs", {12'd0, result, result_hi, carry_out, zero, negative, overflow}, 0);
    check("reset_in_ready", {31'd0, in_ready}, 1);

    // Back-to-back stream; expected C tracks the stored flag by hand.
    send("add_ff_01", 4'b0000, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100);
    send("adc_chain", 4'b0010, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000);
    send("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001);
    send("and_zero",  4'b0100, 8'hF0, 8'h0F, 8'h00, 8'h00, 4'b0100);
    drain("drain_1");

    // Backpressure with a C=1 result pending.
    @(negedge clk);
    out_ready = 1'b0;
    send("add_c0_50", 4'b0000, 8'hC0, 8'h50, 8'h10, 8'h00, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'h10});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 1);

    send("xor_c_held", 4'b0110, 8'hAA, 8'hFF, 8'h55, 8'h00, 4'b1000);
    send("sbc_borrow", 4'b0011, 8'h10, 8'h05, 8'h0A, 8'h00, 4'b0000);
    send("or",         4'b0101, 8'h0F, 8'h30, 8'h3F, 8'h00, 4'b0000);
    send("nor_zero",   4'b0111, 8'h0F, 8'hF0, 8'h00, 8'h00, 4'b0100);
    send("nand",       4'b1000, 8'hF0, 8'h3C, 8'hCF, 8'h00, 4'b0010);
    send("xnor",       4'b1001, 8'h0F, 8'h0F, 8'hFF, 8'h00, 4'b0010);
    send("lt_true",    4'b1010, 8'h03, 8'h05, 8'h01, 8'h00, 4'b0000);
    send("gt_true",    4'b1011, 8'h05, 8'h03, 8'h01, 8'h00, 4'b0000);
    send("eq_true",    4'b1100, 8'h05, 8'h05, 8'h01, 8'h00, 4'b0000);
    send("lt_false",   4'b1010, 8'h05, 8'h03, 8'h00, 8'h00, 4'b0100);
    send("shl_1",      4'b1110, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0000);
    send("shr_7",      4'b1111, 8'h81, 8'h07, 8'h01, 8'h00, 4'b0000);
    send("shl_7",      4'b1110, 8'h01, 8'h07, 8'h80, 8'h00, 4'b0010);
    send("sub_borrow", 4'b0001, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b1010);
    send("adc_ovf",    4'b0010, 8'h7F, 8'h00, 8'h80, 8'h00, 4'b0011);
    drain("drain_2");

`ifdef ALU_MUL_EN
    send("mul_ff_ff", 4'b1101, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000);
`else
    send("mul_ff_ff", 4'b1101, 8'hFF, 8'hFF, 8'hFE, 8'h00, 4'b1010);
`endif
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_latency", n, MUL_LAT);
    drain("drain_3");

`ifdef ALU_MUL_EN
    send("mul_zero", 4'b1101, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100);
    drain("drain_4");

    // Reset while the multiplier is running.
    send("mul_aborted", 4'b1101, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("abort_no_valid", {31'd0, seen}, 0);
    check("abort_outputs", {12'd0, result, result_hi, carry_out, zero, negative, overflow}, 0);
    check("abort_in_ready", {31'd0, in_ready}, 1);
`else
    send("mul_as_add", 4'b1101, 8'h00, 8'h37, 8'h37, 8'h00, 4'b0000);
    drain("drain_4");
`endif

    // Carry-in must be the post-reset C (0), not whatever preceded.
    send("post_add", 4'b0000, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000);
    send("post_adc", 4'b0010, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
